icache_tag_ctrl: RTL

ICACHE_TAG_CTRL -- requirements
Module: icache_tag_ctrl

---
 rtl/icache_tag_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/icache_tag_ctrl.sv
// Direct-mapped instruction-cache tag controller: external 1W/1R tag RAM, valid bits in flops,
// one outstanding refill. Define ICACHE_FLUSH_EN to add the flush port and pending-flush logic.
module icache_tag_ctrl #(
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [31:0]            resp_addr,
  output logic                   refill_req,
  output logic [31:0]            refill_addr,
  input  logic                   refill_ack,
  output logic                   tag_csb0,
  output logic [INDEX_WIDTH-1:0] tag_addr0,
  output logic [TAG_WIDTH-1:0]   tag_din0,
  output logic                   tag_csb1,
  output logic [INDEX_WIDTH-1:0] tag_addr1,
  input  logic [TAG_WIDTH-1:0]   tag_dout1
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  localparam int ADDR_WIDTH = 32;
  localparam int NUM_SETS   = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    FILL   = 2'd3
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [NUM_SETS-1:0]     valid_reg;

  logic [TAG_WIDTH-1:0]    lat_tag;
  logic [INDEX_WIDTH-1:0]  lat_index;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic                    flush_apply;
  logic                    accept;
  logic                    lookup_hit;
  logic                    fill_en;

  assign lat_tag   = addr_reg[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign lat_index = addr_reg[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_index = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];

  // A flush due in IDLE takes the whole cycle, so no request is accepted alongside it.
  assign accept     = (state_reg == IDLE) && !flush_apply && req_valid;
  assign lookup_hit = valid_reg[lat_index] && (tag_dout1 == lat_tag);
  assign fill_en    = (state_reg == FILL);

`ifdef ICACHE_FLUSH_EN
  logic flush_pending_reg;

  assign flush_apply = (state_reg == IDLE) && (flush || flush_pending_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending_reg <= 1'b0;
    end else if (flush_apply) begin
      flush_pending_reg <= 1'b0;
    end else if (flush) begin
      flush_pending_reg <= 1'b1;
    end
  end
`else
  assign flush_apply = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else if (accept) begin
      addr_reg <= req_addr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_valid
      logic v_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg <= 1'b0;
        end else if (flush_apply) begin
          v_reg <= 1'b0;
        end else if (fill_en && (lat_index == INDEX_WIDTH'(gi))) begin
          v_reg <= 1'b1;
        end
      end
      assign valid_reg[gi] = v_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LOOKUP;
      LOOKUP:  state_next = lookup_hit ? IDLE : REFILL;
      REFILL:  if (refill_ack) state_next = FILL;
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    refill_req = 1'b0;
    tag_csb0   = 1'b1;
    tag_csb1   = 1'b1;
    case (state_reg)
      IDLE: begin
        req_ready = !flush_apply;
        tag_csb1  = !accept;
      end
      LOOKUP: begin
        resp_valid = lookup_hit;
        resp_hit   = lookup_hit;
      end
      REFILL: begin
        refill_req = 1'b1;
      end
      FILL: begin
        tag_csb0   = 1'b0;
        resp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Read index follows the request port so the RAM read launches in the accept cycle.
  assign tag_addr1   = req_index;
  assign tag_addr0   = lat_index;
  assign tag_din0    = lat_tag;
  assign resp_addr   = addr_reg;
  assign refill_addr = {addr_reg[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

endmodule
